// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable N-bit down-counter with start / pause / abort control. Used as a
//   programmable delay or timeout source. A one-cycle registered `done` pulse
//   marks terminal count; a start with an effective value of zero produces an
//   immediate done without leaving IDLE.
//
//   Optional feature (compile-time macro AUTO_RELOAD_EN):
//     defined   - on terminal count the counter reloads from the reload
//                 register and keeps running (free-running period timer).
//     undefined - one-shot; the reload register is not built.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   load      in   capture load_val into count (and reload), IDLE only
//   load_val  in   [N-1:0] value to load
//   start     in   begin countdown, IDLE only
//   pause     in   level; freezes count while running
//   abort     in   stop immediately, no done
//   count     out  [N-1:0] current counter value (registered)
//   busy      out  high in RUN and PAUSED
//   done      out  one-cycle registered pulse on reaching terminal count
//   zero      out  count == 0 (decoded from the registered count)
module countdown_timer #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         done_q,  done_d;
    logic [N-1:0] count_dec;
    logic [N-1:0] eff_val;
`ifdef AUTO_RELOAD_EN
    logic [N-1:0] reload_q, reload_d;
`endif

    // Ripple-borrow decrementer: borrow enters at bit 0 and propagates
    // through every trailing zero.
    function automatic logic [N-1:0] dec_ripple(input logic [N-1:0] v);
        logic [N-1:0] borrow;
        borrow    = '0;
        borrow[0] = 1'b1;
        for (int unsigned i = 1; i < N; i++) begin
            borrow[i] = ~v[i-1] & borrow[i-1];
        end
        return v ^ borrow;
    endfunction

    assign count_dec = dec_ripple(count_q);
    // A same-cycle load feeds start directly, so start sees the new value.
    assign eff_val   = load ? load_val : count_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!abort) begin
                    if (load) begin
                        count_d  = load_val;
`ifdef AUTO_RELOAD_EN
                        reload_d = load_val;
`endif
                    end
                    if (start) begin
                        if (eff_val != '0) begin
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (count_q == N'(1)) begin
                    done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                    count_d = reload_q;
`else
                    count_d = '0;
                    state_d = IDLE;
`endif
                end else begin
                    count_d = count_dec;
                end
            end
            PAUSED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: the stimulus process advances a
// behavioural timer model each edge and queues the expected outputs; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_countdown_timer;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [N-1:0] load_val;
    logic         start;
    logic         pause;
    logic         abort;
    logic [N-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;

    countdown_timer #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit done;
        bit zero;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model: remaining ticks, reload value, and whether the timer
    // is active and/or frozen.
    int m_cnt    = 0;
    int m_rel    = 0;
    bit m_active = 0;
    bit m_frozen = 0;

    task automatic cmp(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rel = 0; m_active = 0; m_frozen = 0;
    endtask

    task automatic model_edge(input bit l, input int lv, input bit s, input bit p,
                              input bit a, output bit dn);
        dn = 0;
        if (!m_active) begin
            if (!a) begin
                if (l) begin m_cnt = lv; m_rel = lv; end
                if (s) begin
                    if (m_cnt != 0) begin m_active = 1; m_frozen = 0; end
                    else dn = 1;
                end
            end
        end else if (a) begin
            m_active = 0;
            m_frozen = 0;
        end else if (m_frozen) begin
            if (!p) m_frozen = 0;
        end else if (p) begin
            m_frozen = 1;
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                dn = 1;
`ifdef AUTO_RELOAD_EN
                m_cnt = m_rel;
`else
                m_active = 0;
`endif
            end
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; the model advances
    // on the next rising edge and the expected outputs are queued.
    task automatic step(input bit l, input int lv, input bit s, input bit p, input bit a);
        exp_t e;
        bit   dn;
        load = l; load_val = lv[N-1:0]; start = s; pause = p; abort = a;
        @(posedge clk);
        model_edge(l, lv, s, p, a, dn);
        e.count = m_cnt;
        e.busy  = m_active;
        e.done  = dn;
        e.zero  = (m_cnt == 0);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, "_count"}, int'(count), 0);
        cmp({tag, "_busy"},  int'(busy),  0);
        cmp({tag, "_done"},  int'(done),  0);
        cmp({tag, "_zero"},  int'(zero),  1);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("count", int'(count), e.count);
            cmp("busy",  int'(busy),  int'(e.busy));
            cmp("done",  int'(done),  int'(e.done));
            cmp("zero",  int'(zero),  int'(e.zero));
        end
    end

    initial begin
        bit p_lvl;
        rst_n = 1'b0;
        load = 0; load_val = '0; start = 0; pause = 0; abort = 0;
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Plain one-shot: load 6 then start.
        step(1, 6, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(8);

        // Load and start together; a load while busy is ignored.
        step(1, 9, 1, 0, 0);
        idle(4);
        step(1, 3, 0, 0, 0);
        idle(7);

        // Pause at 7 for four cycles, then release.
        step(1, 10, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        idle(10);

        // Abort at 8, then resume from the held count.
        step(1, 12, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 1, 0, 0);
        idle(10);

        // Zero-length timeouts, separate and same-cycle load.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 1, 0, 0);
        idle(2);

        // Terminal count of the largest value.
        step(1, (1 << N) - 1, 1, 0, 0);
        idle(18);

`ifdef AUTO_RELOAD_EN
        step(1, 3, 1, 0, 0);
        idle(10);
        step(0, 0, 0, 0, 1);
        idle(3);
        step(1, 1, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1);
        idle(2);
`endif

        // Asynchronous reset while running at count 5: no done afterwards.
        step(1, 8, 1, 0, 0);
        idle(3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun_reset");
        @(posedge clk);
        #1;
        check_reset_vals("reset_held");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Randomized traffic.
        p_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            bit l, s, a;
            int lv;
            l  = ($urandom % 6) == 0;
            s  = ($urandom % 5) == 0;
            a  = ($urandom % 40) == 0;
            lv = $urandom_range(0, (1 << N) - 1);
            if (($urandom % 8) == 0) p_lvl = ~p_lvl;
            if (a) begin l = 0; s = 0; end
            step(l, lv, s, p_lvl, a);
        end
        idle(2);

        @(negedge clk);
        #1;
        cmp("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable N-bit down-counter with start/pause/abort control and a one-cycle `done` pulse at terminal count.
- The decrement path is a ripple-borrow chain, the subtract-direction counterpart of the arithmetic library's ripple-carry incrementor.
- Used as a programmable delay/timeout source by control FSMs elsewhere in the design.

Parameters:
- N, 4, counter width in bits; legal range 4..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture load_val into count and the reload register (IDLE only)
- load_val  input  N  value to load
- start  input  1  begin countdown (IDLE only)
- pause  input  1  level; freezes count while running
- abort  input  1  stop immediately, no done
- count  output  N  current counter value (registered)
- busy  output  1  high in RUN and PAUSED
- done  output  1  one-cycle registered pulse on reaching zero
- zero  output  1  combinational, count == 0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, async): state=IDLE, count=0, reload register=0, busy=0, done=0; zero=1.
- States:
  - IDLE: accepts load/start.
  - RUN: decrementing.
  - PAUSED: holding.
- Priority per edge: abort > load > start > pause.
- done: defaults to 0 every edge; set only as described below.
- IDLE:
  - load=1: count<=load_val; reload<=load_val.
  - start=1, effective value != 0: go to RUN, busy=1. The effective value is load_val if load is also high this cycle, otherwise count.
  - start=1, effective value == 0: stay IDLE; done=1 next cycle (zero-length timeout).
  - pause in IDLE: ignored.
- RUN:
  - pause=1: go to PAUSED; count holds.
  - count>1: count<=count-1.
  - count==1: count<=0, done=1, busy=0, go to IDLE.
- PAUSED:
  - count holds.
  - pause=0: return to RUN. The first decrement happens on the edge after the one where pause is seen low.
- load/start while busy: ignored, with no effect on count or reload.
- abort:
  - In RUN or PAUSED: go to IDLE, busy=0, count holds its current value, done=0.
  - In IDLE: no effect.
  - A subsequent start resumes from the held count.
- Latency: start at edge 0 with count=V (V>=1) → count reaches 0 and done=1 after edge V, i.e. done is visible in cycle V.
- Decrement arithmetic:
  - borrow[0]=1
  - d[i]=count[i]^borrow[i]
  - borrow[i+1]=~count[i]&borrow[i]
  - Wrap 0→2^N-1 is structurally possible but unreachable, since RUN never decrements from 0.
- Reset mid-run: immediate return to reset values; no done is emitted.
- zero is derived from registered count only (glitch-free relative to clk).

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined: in RUN with count==1, the next edge sets count<=reload and done=1. State stays RUN and busy stays 1, so the timer free-runs with period = reload cycles. pause/abort behave as above; abort is the only way back to IDLE besides reset. If reload==1, done is high every cycle.
- Undefined: one-shot behaviour as specified; the reload register may be optimized away.

Test Plan:
- Reset with N=4 → count=0, busy=0, done=0, zero=1; assert rst_n low mid-RUN at count=5 → outputs return to reset values asynchronously, no done.
- load_val=6 with load=1, then start=1 → busy=1; count steps 6,5,4,3,2,1,0; done=1 for exactly one cycle coincident with count=0; busy=0 in the same cycle.
- load_val=9 with load and start in the same cycle → count 9..0, done after 9 edges; a later load=1 with load_val=3 while busy → ignored, count unaffected.
- Load 10, start, pause high at count=7 for 4 cycles → count holds 7, busy=1; release → 6 on the following edge; done after 7 further edges total.
- Load 12, start, abort at count=8 → IDLE, count=8, no done; start again → counts 7..0, done pulses once.
- Load 0, start → stays IDLE, done=1 one cycle; with AUTO_RELOAD_EN, load 3 and start → done every 3 cycles, count 3,2,1,3,2,1…; abort → IDLE.
